// File: rtl/wb_cmd_master_pkg.sv
// rtl/wb_cmd_master_pkg.sv - shared state encodings and default timeout for wb_cmd_master
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        WBM_IDLE = 2'd0,
        WBM_BUS  = 2'd1,
        WBM_RESP = 2'd2
    } wbm_state_e;

    localparam logic [15:0] WBM_TIMEOUT_DEFAULT = 16'd1023;

endpackage

// File: rtl/wbm_timeout.sv
// rtl/wbm_timeout.sv - bus-wait counter with clear, enable and expiry flag
module wbm_timeout
    import wb_cmd_master_pkg::*;
#(
    parameter logic [15:0] LIMIT = WBM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Clear wins over counting so the count always starts at 0 on entry to BUS.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry only counts on a waiting cycle, so an ack on the same cycle wins.
    assign expired = en && (cnt_q == (LIMIT - 16'd1));

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-cycle command master; timeout built with WB_CMD_MASTER_TIMEOUT_EN
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = WBM_TIMEOUT_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [1:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [15:0] cmd_dat,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_dat,
    output logic        resp_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i
);

    wbm_state_e  state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic        resp_valid_q, resp_valid_d;
    logic [15:0] resp_dat_q, resp_dat_d;
    logic        resp_err_q, resp_err_d;
    logic        timeout_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    wbm_timeout #(
        .LIMIT   (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (state_q != WBM_BUS),
        .en      ((state_q == WBM_BUS) && !wb_ack_i),
        .expired (timeout_hit)
    );
`else
    localparam bit unused_timeout = |TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output logic for the IDLE -> BUS -> RESP handshake.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        resp_valid_d = resp_valid_q;
        resp_dat_d   = resp_dat_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            WBM_IDLE: begin
                if (cmd_valid) begin
                    we_d        = cmd_we;
                    sel_d       = cmd_sel;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                    cyc_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = WBM_BUS;
                end
            end
            WBM_BUS: begin
                if (wb_ack_i) begin
                    cyc_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_dat_d   = we_q ? 16'h0000 : wb_dat_i;
                    resp_err_d   = 1'b0;
                    state_d      = WBM_RESP;
                end else if (timeout_hit) begin
                    cyc_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_dat_d   = 16'h0000;
                    resp_err_d   = 1'b1;
                    state_d      = WBM_RESP;
                end
            end
            WBM_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    state_d      = WBM_IDLE;
                end
            end
            default: begin
                cyc_d        = 1'b0;
                resp_valid_d = 1'b0;
                cmd_ready_d  = 1'b1;
                state_d      = WBM_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any bus cycle or pending response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= WBM_IDLE;
            cmd_ready_q  <= 1'b1;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 2'b00;
            adr_q        <= 32'h0;
            dat_q        <= 16'h0;
            resp_valid_q <= 1'b0;
            resp_dat_q   <= 16'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            resp_valid_q <= resp_valid_d;
            resp_dat_q   <= resp_dat_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_dat   = resp_dat_q;
    assign resp_err   = resp_err_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_sel_o   = sel_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [1:0]  cmd_sel = 2'b00;
    logic [31:0] cmd_adr = 32'h0;
    logic [15:0] cmd_dat = 16'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_dat;
    logic        resp_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;

    // responder: mode 0 acks in the strobe cycle, 1 never acks, 2 acks in cycle ack_at
    int          ack_mode = 0;
    int          ack_at = 1;
    int          age = 0;
    logic        stray_ack = 1'b0;
    logic [15:0] rmem [16];
    logic [15:0] ref_mem [16];

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(16'd8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_sel    (cmd_sel),
        .cmd_adr    (cmd_adr),
        .cmd_dat    (cmd_dat),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_dat   (resp_dat),
        .resp_err   (resp_err),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    assign wb_dat_i = rmem[wb_adr_o[4:1]];
    assign wb_ack_i = ((ack_mode == 0) && wb_cyc_o && wb_stb_o)
                    || ((ack_mode == 2) && wb_cyc_o && (age == ack_at - 1))
                    || stray_ack;

    always @(posedge clk) begin
        age <= wb_cyc_o ? age + 1 : 0;
        if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) begin
            if (wb_sel_o[0]) rmem[wb_adr_o[4:1]][7:0]  <= wb_dat_o[7:0];
            if (wb_sel_o[1]) rmem[wb_adr_o[4:1]][15:8] <= wb_dat_o[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_write(input int idx, input logic [1:0] sel, input logic [15:0] dat);
        logic [15:0] w;
        w = ref_mem[idx];
        w = {sel[1] ? dat[15:8] : w[15:8], sel[0] ? dat[7:0] : w[7:0]};
        ref_mem[idx] = w;
    endfunction

    // full transaction; lat counts cycles from accept edge to the edge raising resp_valid
    task automatic run_txn(input logic we, input logic [1:0] sel, input logic [31:0] adr,
                           input logic [15:0] dat, output logic [15:0] rdat, output logic err,
                           output int lat, output int ncyc, output logic [31:0] badr,
                           output logic bwe, output logic [1:0] bsel, output logic [15:0] bdat,
                           output logic rdy_after);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("accept_bound", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        badr = wb_adr_o; bwe = wb_we_o; bsel = wb_sel_o; bdat = wb_dat_o;
        lat = 1; ncyc = 0;
        while (!resp_valid && lat < 100) begin
            if (wb_cyc_o) ncyc++;
            @(negedge clk);
            lat++;
        end
        rdat = resp_dat; err = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        rdy_after = cmd_ready;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [31:0] adr;
        logic [15:0] dat;
        logic [15:0] exp_dat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [15:0] rdat;
        logic        err, bwe, rdy;
        logic [31:0] badr;
        logic [1:0]  bsel;
        logic [15:0] bdat;
        int          lat, ncyc, n;

        for (int i = 0; i < 16; i++) begin rmem[i] = 16'h0; ref_mem[i] = 16'h0; end

        vecs[0] = '{1'b1, 2'b11, 32'h08, 16'h1234, 16'h0000};
        vecs[1] = '{1'b0, 2'b11, 32'h08, 16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 2'b01, 32'h08, 16'h00AB, 16'h0000};
        vecs[3] = '{1'b0, 2'b11, 32'h08, 16'h0000, 16'h12AB};
        vecs[4] = '{1'b1, 2'b00, 32'h08, 16'hFFFF, 16'h0000};
        vecs[5] = '{1'b0, 2'b10, 32'h08, 16'h0000, 16'h12AB};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_dat", 32'(resp_dat), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_bus", {wb_we_o, wb_sel_o, wb_dat_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        rst = 1'b0;

        // directed table
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat,
                    rdat, err, lat, ncyc, badr, bwe, bsel, bdat, rdy);
            if (vecs[i].we) model_write(int'(vecs[i].adr[4:1]), vecs[i].sel, vecs[i].dat);
            chk($sformatf("vec%0d_dat", i), 32'(rdat), 32'(vecs[i].exp_dat));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'd0);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_ncyc", i), 32'(ncyc), 32'd1);
            chk($sformatf("vec%0d_adr", i), badr, vecs[i].adr);
            chk($sformatf("vec%0d_we", i), 32'(bwe), 32'(vecs[i].we));
            chk($sformatf("vec%0d_sel", i), 32'(bsel), 32'(vecs[i].sel));
            if (vecs[i].we) chk($sformatf("vec%0d_wdat", i), 32'(bdat), 32'(vecs[i].dat));
            chk($sformatf("vec%0d_ready_after", i), 32'(rdy), 32'd1);
        end

        // randomized traffic against the memory model
        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [1:0]  sel;
            logic [15:0] dat, exp;
            int          idx;
            we  = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            idx = $urandom_range(0, 15);
            dat = 16'($urandom);
            exp = we ? 16'h0000 : ref_mem[idx];
            run_txn(we, sel, 32'(idx * 2), dat, rdat, err, lat, ncyc, badr, bwe, bsel, bdat, rdy);
            if (we) model_write(idx, sel, dat);
            chk($sformatf("rnd%0d_dat", i), 32'(rdat), 32'(exp));
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'd0);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd2);
        end

        // response back-pressure with a second command waiting
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 2'b11; cmd_adr = 32'h10; cmd_dat = 16'h5555;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_we = 1'b0; cmd_dat = 16'h0000;
        model_write(8, 2'b11, 16'h5555);
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        chk("hold_resp_seen", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("hold%0d_dat", i), 32'(resp_dat), 32'd0);
            chk($sformatf("hold%0d_ready", i), 32'(cmd_ready), 32'd0);
            chk($sformatf("hold%0d_cyc", i), 32'(wb_cyc_o), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("hold_release_ready", 32'(cmd_ready), 32'd1);
        chk("hold_release_cyc", 32'(wb_cyc_o), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("hold_second_cyc", 32'(wb_cyc_o), 32'd1);
        chk("hold_second_we", 32'(wb_we_o), 32'd0);
        n = 0;
        while (!resp_valid && n < 50) begin @(negedge clk); n++; end
        chk("hold_second_dat", 32'(resp_dat), 32'(ref_mem[8]));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // no ack: abort after TIMEOUT=8 strobe cycles
        ack_mode = 1;
        run_txn(1'b1, 2'b11, 32'h02, 16'hBEEF, rdat, err, lat, ncyc, badr, bwe, bsel, bdat, rdy);
        chk("to_err", 32'(err), 32'd1);
        chk("to_dat", 32'(rdat), 32'd0);
        chk("to_ncyc", 32'(ncyc), 32'd8);
        chk("to_lat", 32'(lat), 32'd9);
        chk("to_ready_after", 32'(rdy), 32'd1);
        // ack on the expiry cycle wins
        ack_mode = 2; ack_at = 8;
        run_txn(1'b0, 2'b11, 32'h08, 16'h0000, rdat, err, lat, ncyc, badr, bwe, bsel, bdat, rdy);
        chk("ack8_err", 32'(err), 32'd0);
        chk("ack8_dat", 32'(rdat), 32'(ref_mem[4]));
        chk("ack8_ncyc", 32'(ncyc), 32'd8);
        ack_at = 3;
        run_txn(1'b0, 2'b11, 32'h10, 16'h0000, rdat, err, lat, ncyc, badr, bwe, bsel, bdat, rdy);
        chk("ack3_err", 32'(err), 32'd0);
        chk("ack3_lat", 32'(lat), 32'd4);
        chk("ack3_dat", 32'(rdat), 32'(ref_mem[8]));
        ack_mode = 0;
`else
        // without the timeout the master waits for a slow ack
        ack_mode = 2; ack_at = 20;
        run_txn(1'b0, 2'b11, 32'h08, 16'h0000, rdat, err, lat, ncyc, badr, bwe, bsel, bdat, rdy);
        chk("slow_err", 32'(err), 32'd0);
        chk("slow_lat", 32'(lat), 32'd21);
        chk("slow_dat", 32'(rdat), 32'(ref_mem[4]));
        ack_mode = 0;
`endif

        // reset during BUS, then a late ack
        ack_mode = 1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 2'b11; cmd_adr = 32'h04;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rbus_cyc_before", 32'(wb_cyc_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rbus_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rbus_stb", 32'(wb_stb_o), 32'd0);
        chk("rbus_ready", 32'(cmd_ready), 32'd1);
        chk("rbus_valid", 32'(resp_valid), 32'd0);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("late_ack%0d_valid", i), 32'(resp_valid), 32'd0);
            chk($sformatf("late_ack%0d_cyc", i), 32'(wb_cyc_o), 32'd0);
            chk($sformatf("late_ack%0d_ready", i), 32'(cmd_ready), 32'd1);
            @(negedge clk);
        end
        ack_mode = 0;

        // stray ack in IDLE
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_valid", 32'(resp_valid), 32'd0);
        chk("stray_ready", 32'(cmd_ready), 32'd1);
        chk("stray_cyc", 32'(wb_cyc_o), 32'd0);

        // master still works afterwards
        run_txn(1'b0, 2'b11, 32'h08, 16'h0000, rdat, err, lat, ncyc, badr, bwe, bsel, bdat, rdy);
        chk("final_dat", 32'(rdat), 32'(ref_mem[4]));
        chk("final_lat", 32'(lat), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
